// File: rtl/bnn_conv_pool_layer.sv
// Binary 3x3 XNOR-popcount convolution with per-filter threshold and 2x2 OR pooling.
// Streams one pooled bit per accepted cycle and accumulates the full output bitmap.

module bnn_conv_pool_win #(
  parameter  int IN_DIM = 14,
  parameter  int IN_CH  = 8,
  parameter  int CNT_W  = 7,
  localparam int AW     = $clog2(IN_DIM),
  localparam int PW     = $clog2(IN_DIM*IN_DIM)
) (
  input  logic [IN_DIM*IN_DIM*IN_CH-1:0] i_pixels,
  input  logic [9*IN_CH-1:0]             i_w,
  input  logic [AW-1:0]                  i_y,
  input  logic [AW-1:0]                  i_x,
  output logic [CNT_W-1:0]               o_cnt
);
  logic [IN_CH-1:0]   w_pix [IN_DIM*IN_DIM];
  logic [9*IN_CH-1:0] w_match;

  for (genvar p = 0; p < IN_DIM*IN_DIM; p++) begin : g_pix
    assign w_pix[p] = i_pixels[p*IN_CH +: IN_CH];
  end

  for (genvar t = 0; t < 9; t++) begin : g_tap
    localparam int KR = t / 3;
    localparam int KC = t % 3;
    logic            w_vy, w_vx;
    logic [AW-1:0]   w_py, w_px;
    logic [IN_CH-1:0] w_tap;
    // Taps hanging off the map edge read zero pixels
    if (KR == 0) begin : g_ry
      assign w_vy = (i_y != '0);
      assign w_py = i_y - AW'(1);
    end else if (KR == 1) begin : g_ry
      assign w_vy = 1'b1;
      assign w_py = i_y;
    end else begin : g_ry
      assign w_vy = (i_y != AW'(IN_DIM-1));
      assign w_py = i_y + AW'(1);
    end
    if (KC == 0) begin : g_rx
      assign w_vx = (i_x != '0);
      assign w_px = i_x - AW'(1);
    end else if (KC == 1) begin : g_rx
      assign w_vx = 1'b1;
      assign w_px = i_x;
    end else begin : g_rx
      assign w_vx = (i_x != AW'(IN_DIM-1));
      assign w_px = i_x + AW'(1);
    end
    assign w_tap = (w_vy && w_vx) ? w_pix[PW'(w_py)*PW'(IN_DIM) + PW'(w_px)] : '0;
    assign w_match[t*IN_CH +: IN_CH] = ~(w_tap ^ i_w[t*IN_CH +: IN_CH]);
  end

  assign o_cnt = CNT_W'($countones(w_match));
endmodule

module bnn_conv_pool_layer #(
  parameter  int IN_DIM   = 14,
  parameter  int IN_CH    = 8,
  parameter  int NUM_FILT = 4,
  localparam int OUT_DIM  = IN_DIM / 2,
  localparam int CNT_W    = $clog2(9*IN_CH+1),
  localparam int FW       = $clog2(NUM_FILT),
  localparam int OW       = $clog2(OUT_DIM),
  localparam int AW       = $clog2(IN_DIM),
  localparam int KW       = 9*IN_CH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_start,
  input  logic [IN_DIM*IN_DIM*IN_CH-1:0]  i_pixels,
  input  logic [NUM_FILT*KW-1:0]          i_weights,
  input  logic [NUM_FILT*CNT_W-1:0]       i_thresholds,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_out_valid,
  input  logic                            i_out_ready,
  output logic                            o_out_bit,
  output logic [FW-1:0]                   o_out_filt,
  output logic [OW-1:0]                   o_out_row,
  output logic [OW-1:0]                   o_out_col,
  output logic [NUM_FILT*OUT_DIM*OUT_DIM-1:0] o_out_map
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          r_state;
  logic [FW-1:0]   r_filt;
  logic [OW-1:0]   r_row, r_col;
  logic [KW-1:0]   w_karr [NUM_FILT];
  logic [CNT_W-1:0] w_tarr [NUM_FILT];
  logic [CNT_W-1:0] w_cnt [4];
  logic [3:0]      w_hit;
  logic            w_bit, w_last, w_load, w_go;

  for (genvar f = 0; f < NUM_FILT; f++) begin : g_filt
    assign w_karr[f] = i_weights[f*KW +: KW];
    assign w_tarr[f] = i_thresholds[f*CNT_W +: CNT_W];
  end

  // Four conv positions feeding one pooled output
  for (genvar q = 0; q < 4; q++) begin : g_pos
    bnn_conv_pool_win #(.IN_DIM(IN_DIM), .IN_CH(IN_CH), .CNT_W(CNT_W)) u_win (
      .i_pixels (i_pixels),
      .i_w      (w_karr[r_filt]),
      .i_y      (AW'({r_row, (q / 2 == 1)})),
      .i_x      (AW'({r_col, (q % 2 == 1)})),
      .o_cnt    (w_cnt[q])
    );
    assign w_hit[q] = (w_cnt[q] >= w_tarr[r_filt]);
  end

  assign w_bit  = |w_hit;
  assign w_last = (r_filt == FW'(NUM_FILT-1)) && (r_row == OW'(OUT_DIM-1)) &&
                  (r_col == OW'(OUT_DIM-1));
  assign w_load = (r_state == S_RUN) && (!o_out_valid || i_out_ready);
  assign w_go   = (r_state == S_IDLE) && i_start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_filt      <= '0;
      r_row       <= '0;
      r_col       <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_out_valid <= 1'b0;
      o_out_bit   <= 1'b0;
      o_out_filt  <= '0;
      o_out_row   <= '0;
      o_out_col   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_state <= S_RUN;
          o_busy  <= 1'b1;
          r_filt  <= '0;
          r_row   <= '0;
          r_col   <= '0;
        end
        S_RUN: if (w_load) begin
          o_out_valid <= 1'b1;
          o_out_bit   <= w_bit;
          o_out_filt  <= r_filt;
          o_out_row   <= r_row;
          o_out_col   <= r_col;
          if (w_last) r_state <= S_DRAIN;
          if (r_col == OW'(OUT_DIM-1)) begin
            r_col <= '0;
            if (r_row == OW'(OUT_DIM-1)) begin
              r_row  <= '0;
              r_filt <= r_filt + FW'(1);
            end else begin
              r_row <= r_row + OW'(1);
            end
          end else begin
            r_col <= r_col + OW'(1);
          end
        end
        S_DRAIN: if (o_out_valid && i_out_ready) begin
          o_out_valid <= 1'b0;
          o_busy      <= 1'b0;
          o_done      <= 1'b1;
          r_state     <= S_DONE;
        end
        default: begin
          o_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Each map bit latches when its (filt,row,col) is loaded into the output register
  for (genvar m = 0; m < NUM_FILT*OUT_DIM*OUT_DIM; m++) begin : g_map
    localparam int MF = m / (OUT_DIM*OUT_DIM);
    localparam int MR = (m / OUT_DIM) % OUT_DIM;
    localparam int MC = m % OUT_DIM;
    always_ff @(posedge clk) begin
      if (!rst_n || w_go)
        o_out_map[m] <= 1'b0;
      else if (w_load && r_filt == FW'(MF) && r_row == OW'(MR) && r_col == OW'(MC))
        o_out_map[m] <= w_bit;
    end
  end
endmodule

// File: tb/tb_bnn_conv_pool_layer.sv
// Randomized bench for bnn_conv_pool_layer: default instance plus a 28x28x1, 8-filter instance,
// both checked against a direct arithmetic model of conv/threshold/pool.

module tb_bnn_conv_pool_layer;
  localparam int A_DIM = 14, A_CH = 8, A_NF = 4, A_CW = 7, A_OD = 7;
  localparam int B_DIM = 28, B_CH = 1, B_NF = 8, B_CW = 4, B_OD = 14;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, ready = 1'b1;
  int   sel = 0;
  always #5 clk = ~clk;

  logic [A_DIM*A_DIM*A_CH-1:0] a_pix = '0;
  logic [A_NF*9*A_CH-1:0]      a_w   = '0;
  logic [A_NF*A_CW-1:0]        a_thr = '0;
  logic a_start, a_busy, a_done, a_valid, a_bit;
  logic [1:0] a_filt;
  logic [2:0] a_row, a_col;
  logic [A_NF*A_OD*A_OD-1:0] a_map;

  logic [B_DIM*B_DIM*B_CH-1:0] b_pix = '0;
  logic [B_NF*9*B_CH-1:0]      b_w   = '0;
  logic [B_NF*B_CW-1:0]        b_thr = '0;
  logic b_start, b_busy, b_done, b_valid, b_bit;
  logic [2:0] b_filt;
  logic [3:0] b_row, b_col;
  logic [B_NF*B_OD*B_OD-1:0] b_map;

  assign a_start = start && (sel == 0);
  assign b_start = start && (sel == 1);

  bnn_conv_pool_layer #(.IN_DIM(A_DIM), .IN_CH(A_CH), .NUM_FILT(A_NF)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_start(a_start), .i_pixels(a_pix), .i_weights(a_w),
    .i_thresholds(a_thr), .o_busy(a_busy), .o_done(a_done), .o_out_valid(a_valid),
    .i_out_ready(ready), .o_out_bit(a_bit), .o_out_filt(a_filt), .o_out_row(a_row),
    .o_out_col(a_col), .o_out_map(a_map));

  bnn_conv_pool_layer #(.IN_DIM(B_DIM), .IN_CH(B_CH), .NUM_FILT(B_NF)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_start(b_start), .i_pixels(b_pix), .i_weights(b_w),
    .i_thresholds(b_thr), .o_busy(b_busy), .o_done(b_done), .o_out_valid(b_valid),
    .i_out_ready(ready), .o_out_bit(b_bit), .o_out_filt(b_filt), .o_out_row(b_row),
    .o_out_col(b_col), .o_out_map(b_map));

  logic g_valid, g_bit, g_busy, g_done;
  logic [3:0] g_filt, g_row, g_col;
  always_comb begin
    g_valid = a_valid; g_bit = a_bit; g_busy = a_busy; g_done = a_done;
    g_filt = 4'(a_filt); g_row = 4'(a_row); g_col = 4'(a_col);
    if (sel == 1) begin
      g_valid = b_valid; g_bit = b_bit; g_busy = b_busy; g_done = b_done;
      g_filt = 4'(b_filt); g_row = b_row; g_col = b_col;
    end
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  int g_dim, g_ch, g_nf, g_od;
  bit m_pix[], m_w[], m_exp[];
  int m_thr[];

  function automatic logic mapbit(input int idx);
    if (sel == 1) return b_map[idx];
    return a_map[idx];
  endfunction

  // Reference: direct conv over padded map, threshold, OR over the 2x2 pool window
  function automatic void model();
    m_exp = new[g_nf*g_od*g_od];
    for (int f = 0; f < g_nf; f++)
      for (int r = 0; r < g_od; r++)
        for (int c = 0; c < g_od; c++) begin
          bit b = 0;
          for (int d = 0; d < 4; d++) begin
            int y = 2*r + d/2, x = 2*c + d%2, cnt = 0;
            for (int kr = 0; kr < 3; kr++)
              for (int kc = 0; kc < 3; kc++)
                for (int k = 0; k < g_ch; k++) begin
                  int py = y + kr - 1, px = x + kc - 1;
                  bit p = 0;
                  if (py >= 0 && py < g_dim && px >= 0 && px < g_dim)
                    p = m_pix[(py*g_dim + px)*g_ch + k];
                  if (p == m_w[((f*3 + kr)*3 + kc)*g_ch + k]) cnt++;
                end
            if (cnt >= m_thr[f]) b = 1;
          end
          m_exp[(f*g_od + r)*g_od + c] = b;
        end
  endfunction

  // pm/wm: 0 = all zero, 1 = all one, 2 = random
  task automatic prep(input int s, input int pm, input int wm, input int tlo, input int thi);
    sel = s;
    g_dim = (s == 1) ? B_DIM : A_DIM;
    g_ch  = (s == 1) ? B_CH  : A_CH;
    g_nf  = (s == 1) ? B_NF  : A_NF;
    g_od  = g_dim / 2;
    m_pix = new[g_dim*g_dim*g_ch];
    m_w   = new[g_nf*9*g_ch];
    m_thr = new[g_nf];
    foreach (m_pix[i]) m_pix[i] = (pm == 2) ? bit'($urandom_range(1)) : bit'(pm);
    foreach (m_w[i])   m_w[i]   = (wm == 2) ? bit'($urandom_range(1)) : bit'(wm);
    foreach (m_thr[f]) m_thr[f] = int'($urandom_range(thi, tlo));
    model();
    if (s == 0) begin
      foreach (m_pix[i]) a_pix[i] = m_pix[i];
      foreach (m_w[i])   a_w[i]   = m_w[i];
      foreach (m_thr[f]) a_thr[f*A_CW +: A_CW] = A_CW'(m_thr[f]);
    end else begin
      foreach (m_pix[i]) b_pix[i] = m_pix[i];
      foreach (m_w[i])   b_w[i]   = m_w[i];
      foreach (m_thr[f]) b_thr[f*B_CW +: B_CW] = B_CW'(m_thr[f]);
    end
  endtask

  task automatic map_chk(input string tag, input bit zero);
    for (int f = 0; f < g_nf; f++)
      for (int r = 0; r < g_od; r++) begin
        logic [15:0] o = '0, e = '0;
        for (int c = 0; c < g_od; c++) begin
          o[c] = mapbit((f*g_od + r)*g_od + c);
          e[c] = zero ? 1'b0 : m_exp[(f*g_od + r)*g_od + c];
        end
        chk($sformatf("%s_f%0d_r%0d", tag, f, r), 64'(o), 64'(e));
      end
  endtask

  task automatic run(input string tag, input int rdy_pct, input int restart_at, input int rst_at);
    int total = g_nf*g_od*g_od, n = 0, cyc = 0, stall_chg = 0, early = 0, notbusy = 0;
    logic pv = 1'b0, pr = 1'b0;
    logic [15:0] held = '0, cur, e;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, "_lat_busy"}, 64'(g_busy), 64'd1);
    chk({tag, "_lat_vld0"}, 64'(g_valid), 64'd0);
    while (n < total && cyc < 20000) begin
      @(negedge clk); cyc++;
      cur = {3'b0, g_filt, g_row, g_col, g_bit};
      if (cyc == 1) chk({tag, "_lat_vld1"}, 64'(g_valid), 64'd1);
      if (pv && !pr && (!g_valid || cur != held)) stall_chg++;
      if (g_done) early++;
      if (!g_busy) notbusy++;
      if (rst_at >= 0 && n == rst_at) begin
        rst_n = 1'b0; start = 1'b0;
        @(negedge clk);
        chk({tag, "_abort_busy"}, 64'(g_busy), 64'd0);
        chk({tag, "_abort_vld"},  64'(g_valid), 64'd0);
        chk({tag, "_abort_done"}, 64'(g_done), 64'd0);
        map_chk({tag, "_abort_map"}, 1'b1);
        rst_n = 1'b1; ready = 1'b1;
        @(negedge clk);
        return;
      end
      start = (restart_at >= 0 && n == restart_at);
      ready = ($urandom_range(99) < rdy_pct);
      if (g_valid && ready) begin
        e = {3'b0, 4'(n / (g_od*g_od)), 4'((n / g_od) % g_od), 4'(n % g_od), m_exp[n]};
        chk($sformatf("%s_elem%0d", tag, n), 64'(cur), 64'(e));
        n++;
      end
      pv = g_valid; pr = ready; held = cur;
    end
    start = 1'b0;
    chk({tag, "_count"}, 64'(n), 64'(total));
    @(negedge clk);
    chk({tag, "_done_hi"},  64'(g_done), 64'd1);
    chk({tag, "_busy_lo"},  64'(g_busy), 64'd0);
    chk({tag, "_vld_lo"},   64'(g_valid), 64'd0);
    @(negedge clk);
    chk({tag, "_done_one"}, 64'(g_done), 64'd0);
    chk({tag, "_early_done"}, 64'(early), 64'd0);
    chk({tag, "_busy_gap"}, 64'(notbusy), 64'd0);
    chk({tag, "_stall"}, 64'(stall_chg), 64'd0);
    map_chk({tag, "_map"}, 1'b0);
    ready = 1'b1;
  endtask

  initial begin
    prep(0, 0, 0, 72, 72);
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(g_busy), 64'd0);
    chk("rst_vld",  64'(g_valid), 64'd0);
    chk("rst_done", 64'(g_done), 64'd0);
    chk("rst_out",  64'({g_filt, g_row, g_col, g_bit}), 64'd0);
    map_chk("rst_map", 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    prep(0, 0, 0, 72, 72); run("zero72", 100, -1, -1);
    prep(0, 0, 0, 73, 73); run("zero73", 100, -1, -1);
    prep(0, 2, 2, 0, 0);   run("thr0",   100, -1, -1);
    prep(0, 1, 1, 72, 72); run("ones72", 100, -1, -1);
    chk("ones_corner00", 64'(a_map[0]), 64'd1);
    prep(0, 2, 2, 34, 44); run("bp30",   30, -1, -1);
    prep(0, 2, 2, 34, 44); run("restart", 100, 50, -1);
    prep(0, 2, 2, 34, 44); run("abort",  70, -1, 100);
    run("rerun", 100, -1, -1);
    prep(1, 2, 2, 3, 7);   run("sweep",  100, -1, -1);
    prep(1, 2, 2, 2, 8);   run("sweep_bp", 60, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
